csa_serial_accumulator: RTL and testbench

CSA_SERIAL_ACCUMULATOR -- requirements
Module: csa_serial_accumulator

---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_row_3to2.sv | 23 ++
 rtl/csa_serial_accumulator.sv | 130 +++++++++++++
 tb/tb_csa_serial_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save serial accumulator.
// Holds the controller state encoding and the internal accumulator width helper.
// Nothing here carries state; it is imported by the accumulator top and its row.
package csa_pkg;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } csa_state_t;

  // Internal redundant-register width: operand width, extension, plus the carry-out bit.
  function automatic int acc_width(input int w, input int e);
    return w + e + 1;
  endfunction

endpackage

// File: rtl/csa_row_3to2.sv
// Purpose: combinational 3:2 carry-save compressor row, WIDTH bits wide.
// Latency: zero cycles (pure combinational).
// Backpressure: none; consumer decides when outputs are captured.
// Ports: a, b, c  - three addends
//        sum      - bitwise XOR of the addends
//        carry    - bitwise majority shifted up one place (top carry dropped, modulo 2^WIDTH)
module csa_row_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/csa_serial_accumulator.sv
// Purpose: sums N unsigned W-bit operands in carry-save form, then resolves to a W+E+1-bit result.
// Latency: one cycle per accepted operand, then RESOLVE (1 cycle with CSA_ACC_FAST_RESOLVE_EN,
//          otherwise 1..W+E+2 cycles of iterative carry propagation), then result held in OUT.
// Backpressure: in_ready only in ACC; result held stable until out_ready; next batch starts the cycle after.
// Ports: clk, rst_n (synchronous, active-low)
//        in_valid/in_ready/in_data     - operand stream
//        out_valid/out_ready           - result handshake
//        out_sum/out_cout              - registered result, low W+E bits and bit W+E
//        op_cnt                        - operands accepted in the current batch
// Build option: define CSA_ACC_FAST_RESOLVE_EN for a single-cycle adder-based resolve.
module csa_serial_accumulator
  import csa_pkg::*;
#(
  parameter int N = 9,
  parameter int E = 3,
  parameter int W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W+E-1:0]             out_sum,
  output logic                       out_cout,
  output logic [$clog2(N+1)-1:0]     op_cnt
);

  localparam int ACC_W = acc_width(W, E);
  localparam int CNT_W = $clog2(N + 1);

  csa_state_t       state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [ACC_W-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] row_sum;
  logic [ACC_W-1:0] row_carry;

  assign x_ext = ACC_W'(in_data);

  csa_row_3to2 #(
    .WIDTH (ACC_W)
  ) u_row (
    .a     (s_q),
    .b     (c_q),
    .c     (x_ext),
    .sum   (row_sum),
    .carry (row_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      s_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_d   = row_sum;
          c_d   = row_carry;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d = ST_RESOLVE;
          end
        end
      end

      ST_RESOLVE: begin
`ifdef CSA_ACC_FAST_RESOLVE_EN
        r_d     = s_q + c_q;
        state_d = ST_OUT;
`else
        // Ripple one carry step per cycle; S+C is invariant modulo 2^ACC_W,
        // and C empties within ACC_W steps because it only ever shifts upward.
        if (c_q == '0) begin
          r_d     = s_q;
          state_d = ST_OUT;
        end else begin
          s_d = s_q ^ c_q;
          c_d = (s_q & c_q) << 1;
        end
`endif
      end

      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end

      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  assign out_sum  = r_q[ACC_W-2:0];
  assign out_cout = r_q[ACC_W-1];
  assign op_cnt   = cnt_q;

endmodule

// File: tb/tb_csa_serial_accumulator.sv
`timescale 1ns/1ps
module tb_csa_serial_accumulator;

  localparam int N     = 9;
  localparam int E     = 3;
  localparam int W     = 4;
  localparam int ACC_W = W + E + 1;
  localparam int CNT_W = $clog2(N + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W+E-1:0]   out_sum;
  logic             out_cout;
  logic [CNT_W-1:0] op_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [ACC_W-1:0] sb_q[$];

  csa_serial_accumulator #(.N(N), .E(E), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .op_cnt    (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_cnt",    op_cnt,    0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_out_cout",  out_cout,  0);
  endtask

  task automatic send_op(input logic [W-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic send_batch(input logic [W-1:0] vals[N], input bit gaps, input bit do_push);
    logic [ACC_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_data = W'($urandom);
          @(posedge clk); #1;
        end
      end
      send_op(vals[i]);
      sum = sum + ACC_W'(vals[i]);
      chk("op_cnt_step", op_cnt, i + 1);
    end
    chk("in_ready_resolve", in_ready, 0);
    if (do_push) sb_q.push_back(sum);
  endtask

  // Waits for a result, optionally stalls it, compares against the scoreboard, then handshakes.
  task automatic get_result(input int hold, output int lat);
    int cyc;
    logic [ACC_W-1:0] snap;
    logic [ACC_W-1:0] exp;
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = cyc;
    chk("out_valid_wait", out_valid, 1);
    if (!out_valid) return;
    chk("out_in_ready", in_ready, 0);
    snap = {out_cout, out_sum};
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      @(posedge clk); #1;
      chk("hold_valid",    out_valid,           1);
      chk("hold_data",     {out_cout, out_sum}, snap);
      chk("hold_in_ready", in_ready,            0);
    end
    chk("sb_has_entry", sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk("result", snap, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("in_ready_after_hs",  in_ready,  1);
    chk("out_valid_after_hs", out_valid, 0);
    chk("op_cnt_after_hs",    op_cnt,    0);
  endtask

  initial begin
    logic [W-1:0] vals[N];
    int lat;
    int cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    do_reset();

    // Operands 1..9 -> 45
    for (int i = 0; i < N; i++) vals[i] = W'(i + 1);
    send_batch(vals, 1'b0, 1'b1);
    chk("op_cnt_full", op_cnt, N);
    get_result(0, lat);

    // Nine 15s -> 135: sum 7, carry-out 1
    for (int i = 0; i < N; i++) vals[i] = 4'hF;
    send_batch(vals, 1'b0, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    chk("sum_135",  out_sum,  7);
    chk("cout_135", out_cout, 1);
    get_result(0, lat);

    // All zeros -> single resolve cycle
    for (int i = 0; i < N; i++) vals[i] = '0;
    send_batch(vals, 1'b0, 1'b1);
    get_result(0, lat);
    chk("zero_resolve_lat", lat, 1);

    // Output backpressure for 5 cycles with in_valid asserted
    for (int i = 0; i < N; i++) vals[i] = W'(N - i);
    send_batch(vals, 1'b0, 1'b1);
    get_result(5, lat);
    for (int i = 0; i < N; i++) vals[i] = W'(3);
    send_batch(vals, 1'b0, 1'b1);
    get_result(0, lat);

    // Reset after 4 accepted operands, then nine 2s -> 18
    for (int i = 0; i < 4; i++) send_op(W'(7));
    chk("op_cnt_partial", op_cnt, 4);
    do_reset();
    for (int i = 0; i < N; i++) vals[i] = W'(2);
    send_batch(vals, 1'b0, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    chk("sum_18", out_sum, 18);
    get_result(0, lat);

    // Reset right after the last operand (RESOLVE) and in OUT: batch discarded
    for (int i = 0; i < N; i++) vals[i] = W'(9);
    send_batch(vals, 1'b0, 1'b0);
    do_reset();
    send_batch(vals, 1'b0, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    chk("pre_abort_valid", out_valid, 1);
    do_reset();
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_valid", out_valid, 0);
    end

    // Random batches with input gaps and output stalls
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < N; i++) vals[i] = W'($urandom_range(0, (1 << W) - 1));
      send_batch(vals, 1'b1, 1'b1);
      get_result($urandom_range(0, 2), lat);
`ifdef CSA_ACC_FAST_RESOLVE_EN
      chk("fast_resolve_lat", lat, 1);
`else
      chk("resolve_lat_bound", (lat >= 1) && (lat <= W + E + 2), 1);
`endif
    end

    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
